// File: rtl/sdc_pkg.sv
// Shared SD card SPI-mode constants: FSM state encodings, R1 bit positions
// and response lengths.
package sdc_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HUNT = 3'd1;
  localparam logic [2:0] S_R1   = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_BUSY = 3'd4;

  localparam int R1_IDLE      = 0;
  localparam int R1_ERASE_RST = 1;
  localparam int R1_ILLEGAL   = 2;
  localparam int R1_CRC_ERR   = 3;

  localparam int SDC_R1_LEN = 8;
  localparam int SDC_R7_LEN = 40;

endpackage

// File: rtl/sdc_shift_in.sv
// MSB-first serial-in shift register with bit counter and count-reached flag.
// word includes the bit currently presented on din, so callers can capture it in the same edge.
module sdc_shift_in #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  input  logic [5:0]   len,
  output logic [W-1:0] word,
  output logic         last
);

  logic [W-2:0] data;
  logic [5:0]   cnt;

  assign word = {data, din};
  assign last = en && (cnt == len - 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (en) data <= word[W-2:0];
      if (clr)     cnt <= '0;
      else if (en) cnt <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/sdc_resp.sv
// SPI-mode SD response receiver: hunts the start bit, captures R1 or R1+32-bit trailer.
// Optional R1b busy wait is compiled in with SDC_RESP_BUSY_EN.
//
// state | meaning
// IDLE  | waiting for i_start
// HUNT  | sampling MISO for the response start bit (bounded by NCR_BYTES*8)
// R1    | shifting the remaining 7 bits of R1
// PAY   | shifting the 32-bit R3/R7 trailer
// BUSY  | R1b: waiting for MISO to release high (bounded by BUSY_MAX)
module sdc_resp
  import sdc_pkg::*;
#(
  parameter int NCR_BYTES = 8,
  parameter int BUSY_MAX  = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_long,
  input  logic        i_r1b,
  input  logic        i_miso,
  output logic        o_mosi,
  output logic        o_sck_state,
  output logic        o_busy,
  output logic [7:0]  o_r1,
  output logic [31:0] o_payload,
  output logic        o_done,
  output logic        o_timeout
);

  localparam int HW = $clog2(NCR_BYTES*8) + 1;
  localparam logic [HW-1:0] HUNT_LAST = HW'(NCR_BYTES*8 - 1);

  logic [2:0]    state;
  logic          long_q;
  logic [HW-1:0] hunt_cnt;
  logic          sh_en;
  logic          sh_clr;
  logic          sh_last;
  logic [5:0]    sh_len;
  logic [31:0]   sh_word;

`ifdef SDC_RESP_BUSY_EN
  localparam int BW = $clog2(BUSY_MAX) + 1;
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_MAX - 1);
  logic          r1b_q;
  logic [BW-1:0] busy_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = i_r1b ^ (BUSY_MAX != 0);
`endif

  assign o_mosi      = 1'b1;
  assign o_busy      = (state != S_IDLE);
  assign o_sck_state = (state != S_IDLE);

  always_comb begin
    sh_en  = ((state == S_HUNT) && !i_miso) || (state == S_R1) || (state == S_PAY);
    sh_clr = ((state == S_IDLE) && i_start) ||
             (((state == S_R1) || (state == S_PAY)) && sh_last);
    sh_len = (state == S_PAY) ? 6'(SDC_R7_LEN - SDC_R1_LEN) : 6'(SDC_R1_LEN);
  end

  sdc_shift_in #(.W(32)) u_shift (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (sh_clr),
    .en    (sh_en),
    .din   (i_miso),
    .len   (sh_len),
    .word  (sh_word),
    .last  (sh_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      long_q    <= 1'b0;
      hunt_cnt  <= '0;
      o_r1      <= 8'hFF;
      o_payload <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
`ifdef SDC_RESP_BUSY_EN
      r1b_q     <= 1'b0;
      busy_cnt  <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          long_q    <= i_long;
          o_timeout <= 1'b0;
          hunt_cnt  <= '0;
`ifdef SDC_RESP_BUSY_EN
          r1b_q     <= i_r1b;
          busy_cnt  <= '0;
`endif
          state     <= S_HUNT;
        end
        S_HUNT: begin
          if (!i_miso) begin
            hunt_cnt <= '0;
            state    <= S_R1;
          end else if (hunt_cnt == HUNT_LAST) begin
            hunt_cnt  <= '0;
            o_r1      <= 8'hFF;
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
            state     <= S_IDLE;
          end else begin
            hunt_cnt <= hunt_cnt + 1'b1;
          end
        end
        S_R1: if (sh_last) begin
          o_r1 <= sh_word[7:0];
          if (long_q) state <= S_PAY;
`ifdef SDC_RESP_BUSY_EN
          else if (r1b_q) state <= S_BUSY;
`endif
          else begin
            o_done <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_PAY: if (sh_last) begin
          o_payload <= sh_word;
          o_done    <= 1'b1;
          state     <= S_IDLE;
        end
`ifdef SDC_RESP_BUSY_EN
        S_BUSY: begin
          if (i_miso || (busy_cnt == BUSY_LAST)) begin
            busy_cnt  <= '0;
            o_timeout <= !i_miso;
            o_done    <= 1'b1;
            state     <= S_IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
